// File: rtl/cacheline_adaptor.sv
// Cache-line to narrow-burst memory adaptor: one full line per request, moved as `beats` linear beats.
// Optional burst watchdog enabled by defining LINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64,
  parameter int beats    = (8 * (1 << s_offset)) / s_burst
`ifdef LINE_ADAPTOR_TIMEOUT_EN
  , parameter int timeout_cycles = 255
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*(1<<s_offset)-1:0]    line_i,
  input  logic [31:0]                   address_i,
  input  logic                          read_i,
  input  logic                          write_i,
  output logic [8*(1<<s_offset)-1:0]    line_o,
  output logic                          resp_o,
  input  logic [s_burst-1:0]            burst_i,
  input  logic                          resp_i,
  output logic [s_burst-1:0]            burst_o,
  output logic [31:0]                   address_o,
  output logic                          read_o,
  output logic                          write_o,
  output logic                          timeout_o
);

  localparam int L     = 8 * (1 << s_offset);
  localparam int CNT_W = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(beats - 1);
  localparam logic [31:0] ALIGN_MASK = 32'((64'd1 << s_offset) - 64'd1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [L-1:0]     wbuf_q, wbuf_d;
  logic [L-1:0]     line_q, line_d;

`ifdef LINE_ADAPTOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(timeout_cycles + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(timeout_cycles - 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    tmo_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Write has priority when both requests are raised together.
        if (write_i || read_i) begin
          state_d = write_i ? WR_BURST : RD_BURST;
          addr_d  = address_i & ~ALIGN_MASK;
          wbuf_d  = line_i;
          cnt_d   = '0;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      RD_BURST, WR_BURST: begin
        if (resp_i) begin
          if (state_q == RD_BURST) begin
            line_d[cnt_q*s_burst +: s_burst] = burst_i;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end
`ifdef LINE_ADAPTOR_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
`ifdef LINE_ADAPTOR_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          // Memory went silent: finish with whatever beats have arrived.
          state_d    = DONE;
          cnt_d      = '0;
          wait_cnt_d = '0;
          tmo_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
    end
  end

`ifdef LINE_ADAPTOR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
    end
  end
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign read_o    = (state_q == RD_BURST);
  assign write_o   = (state_q == WR_BURST);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = wbuf_q[cnt_q*s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: directed transaction table, mid-burst async reset, randomized traffic.
module tb_cacheline_adaptor;

  localparam int SO    = 5;
  localparam int SB    = 64;
  localparam int L     = 8 * (1 << SO);
  localparam int BEATS = L / SB;

  logic          clk, rst;
  logic [L-1:0]  line_i, line_o;
  logic [31:0]   address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [SB-1:0] burst_i, burst_o;
  logic          resp_i, read_o, write_o, timeout_o;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .resp_i(resp_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [L-1:0] wline;
    logic [L-1:0] rdata;
    logic [15:0]  pat;
    int           plen;
    bit           idle_after;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [L-1:0] exp_line;
  vec_t         vec [6];

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [L-1:0] rand_line();
    logic [L-1:0] v;
    for (int i = 0; i < L / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SB-1:0] beat_of(input logic [L-1:0] ln, input int i);
    return ln[i*SB +: SB];
  endfunction

  // Starts at posedge+1 with the adaptor idle; ends at posedge+1 of the cycle after resp_o.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] exp_addr, input logic [L-1:0] wline,
                        input logic [L-1:0] rdata, input logic [15:0] pat, input int plen);
    bit   exp_rd, exp_wr, r;
    int   k, nb;
    exp_wr = wr;
    exp_rd = rd && !wr;
    read_i = rd; write_i = wr; address_i = addr; line_i = wline;
    resp_i = 1'b0; burst_i = $urandom;
    @(negedge clk);
    chk("req_cycle_busy", {read_o, write_o, resp_o}, 3'b000);
    @(posedge clk); #1;
    k = 0; nb = 0;
    while (nb < BEATS && k < 200) begin
      k++;
      r = (k - 1 < plen) ? pat[k-1] : 1'b1;
      resp_i  = r;
      burst_i = r ? beat_of(rdata, nb) : SB'({$urandom, $urandom});
      address_i = $urandom;
      line_i    = rand_line();
      @(negedge clk);
      chk("burst_rd_wr", {read_o, write_o}, {exp_rd, exp_wr});
      chk("burst_addr", address_o, exp_addr);
      chk("burst_no_resp", {resp_o, timeout_o}, 2'b00);
      if (exp_wr && r) chk("burst_o_beat", burst_o, beat_of(wline, nb));
      if (r) nb++;
      @(posedge clk); #1;
    end
    chk("beat_budget", nb, BEATS);
    resp_i = 1'b0; burst_i = $urandom;
    if (exp_rd) exp_line = rdata;
    @(negedge clk);
    chk("done_resp", {resp_o, read_o, write_o, timeout_o}, 4'b1000);
    chk("done_line", line_o, exp_line);
    chk("done_addr", address_o, exp_addr);
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_after_done", {resp_o, read_o, write_o}, 3'b000);
    chk("idle_line_hold", line_o, exp_line);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    logic [31:0] a;
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    burst_i = '0; line_i = '0; address_i = '0; exp_line = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", {read_o, write_o, resp_o, timeout_o}, 4'b0000);
    chk("rst_line", line_o, '0);
    chk("rst_addr", address_o, 32'h0);
    chk("rst_burst", burst_o, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {read_o, write_o, resp_o}, 3'b000);
    @(posedge clk); #1;

    vec[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0,
               {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h001E, 5, 1'b1};
    vec[1] = '{1'b0, 1'b1, 32'hABCD_EF7F, 32'hABCD_EF60,
               {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, '0, 16'h0000, 0, 1'b1};
    vec[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, '0,
               {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}}, 16'h0059, 7, 1'b0};
    vec[3] = '{1'b1, 1'b0, 32'h1000_0020, 32'h1000_0020, '0,
               {{8{8'hF0}}, {8{8'h0F}}, {8{8'h5A}}, {8{8'hA5}}}, 16'h0000, 0, 1'b0};
    vec[4] = '{1'b0, 1'b1, 32'h2000_003F, 32'h2000_0020,
               {{4{16'h1357}}, {4{16'h2468}}, {4{16'h9BDF}}, {4{16'hACE0}}}, '0, 16'h0002, 3, 1'b0};
    vec[5] = '{1'b1, 1'b1, 32'h0000_0041, 32'h0000_0040,
               {{4{16'h0123}}, {4{16'h4567}}, {4{16'h89AB}}, {4{16'hCDEF}}},
               {4{64'hDEAD_BEEF_DEAD_BEEF}}, 16'h0000, 0, 1'b1};

    foreach (vec[i]) begin
      do_txn(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].exp_addr,
             vec[i].wline, vec[i].rdata, vec[i].pat, vec[i].plen);
      if (vec[i].idle_after) idle_check();
    end

    // Asynchronous reset in the middle of a read burst.
    read_i = 1'b1; address_i = 32'h5555_5555; line_i = rand_line();
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    burst_i = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    chk("pre_rst_busy", read_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {read_o, write_o, resp_o, timeout_o}, 4'b0000);
    chk("mid_rst_line", line_o, '0);
    chk("mid_rst_addr", address_o, 32'h0);
    exp_line = '0;
    @(posedge clk); #1;
    read_i = 1'b0; resp_i = 1'b0; rst = 1'b0;
    idle_check();

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 9);
      a = $urandom;
      do_txn(mode < 5 || mode == 9, mode >= 5, a, (a / 32) * 32, rand_line(), rand_line(),
             16'($urandom), $urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
